bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `w`, which drives the detectors' `w` input. A one-word holding register lets consecutive words stream with no idle bit between them. When no word is in flight, `w` is held at 0, so the detectors see no spurious 1s.

---
 rtl/serial_pkg.sv | 8 +
 rtl/bit_serializer.sv | 117 +++++++++++
 tb/tb_bit_serializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Types and constants shared by the serial front end and its pattern detectors.
package serial_pkg;

   typedef enum logic {IDLE, SHIFT} ser_state_t;

   localparam int SER_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit
// per clock out on w, with a one-word holding register for gapless streaming.
module bit_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             w,
   output logic             w_valid,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ser_state_t       state_reg, state_next;
   logic [WIDTH-1:0] sreg_reg, sreg_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;

   logic [WIDTH-1:0] shifted;
   logic             out_bit;
   logic             accept;
   logic             last_bit;

   // Shift toward the output end, zero-filling the vacated position.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
         if (gi == 0) begin : g_fill
            assign shifted[gi] = 1'b0;
         end else begin : g_move
            assign shifted[gi] = sreg_reg[gi-1];
         end
      end else begin : g_lsb
         if (gi == WIDTH - 1) begin : g_fill
            assign shifted[gi] = 1'b0;
         end else begin : g_move
            assign shifted[gi] = sreg_reg[gi+1];
         end
      end
   end

   if (MSB_FIRST) begin : g_out_msb
      assign out_bit = sreg_reg[WIDTH-1];
   end else begin : g_out_lsb
      assign out_bit = sreg_reg[0];
   end

   assign din_ready = !hold_full_reg && !rst;
   assign accept    = din_valid && din_ready;
   assign w_valid   = (state_reg == SHIFT);
   assign last_bit  = (cnt_reg == CNT_LAST);
   assign last      = w_valid && last_bit;
   assign w         = w_valid && out_bit;

   always_comb begin
      state_next     = state_reg;
      sreg_next      = sreg_reg;
      cnt_next       = cnt_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               sreg_next  = din;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (!last_bit) begin
               sreg_next = shifted;
               cnt_next  = cnt_reg + CW'(1);
               if (accept) begin
                  hold_next      = din;
                  hold_full_next = 1'b1;
               end
            end else if (hold_full_reg) begin
               sreg_next      = hold_reg;
               hold_full_next = 1'b0;
               cnt_next       = '0;
            end else if (accept) begin
               // Word arriving on the final bit goes straight to the shifter.
               sreg_next = din;
               cnt_next  = '0;
            end else begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         sreg_reg      <= '0;
         cnt_reg       <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sreg_reg      <= sreg_next;
         cnt_reg       <= cnt_next;
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances on shared stimulus,
// checked against a word-queue model plus fixed vectors and corner sequences.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         m_ready, m_w, m_wv, m_last;
   logic         l_ready, l_w, l_wv, l_last;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(m_ready), .w(m_w), .w_valid(m_wv), .last(m_last)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(l_ready), .w(l_w), .w_valid(l_wv), .last(l_last)
   );

   typedef struct {
      logic         r;
      logic         v;
      logic [W-1:0] d;
      logic         ew;
      logic         ewv;
      logic         elast;
      logic         erdy;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   // Model: words queued for output (current first, then held) and bit position.
   logic [W-1:0] q[$];
   int           pos = 0;

   // Serial stream collectors, first bit ends up most significant.
   bit           col_en = 1'b0;
   logic [31:0]  col_m, col_l;
   int           col_m_n, col_l_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
      rst = r;
      din_valid = v;
      din = d;
      #3;
   endtask

   task automatic model_check();
      logic erdy, ewv, elast, ewm, ewl;
      erdy  = !rst && (q.size() < 2);
      ewv   = q.size() > 0;
      elast = ewv && (pos == W - 1);
      ewm   = ewv ? q[0][W-1-pos] : 1'b0;
      ewl   = ewv ? q[0][pos] : 1'b0;
      chk("m_ready", 32'(m_ready), 32'(erdy));
      chk("m_w_valid", 32'(m_wv), 32'(ewv));
      chk("m_w", 32'(m_w), 32'(ewm));
      chk("m_last", 32'(m_last), 32'(elast));
      chk("l_ready", 32'(l_ready), 32'(erdy));
      chk("l_w_valid", 32'(l_wv), 32'(ewv));
      chk("l_w", 32'(l_w), 32'(ewl));
      chk("l_last", 32'(l_last), 32'(elast));
   endtask

   task automatic finish_cycle();
      logic acc;
      acc = din_valid && !rst && (q.size() < 2);
      if (acc) $display("accept word %02h at %0t (queued %0d)", din, $time, q.size());
      if (col_en && m_wv) begin col_m = {col_m[30:0], m_w}; col_m_n++; end
      if (col_en && l_wv) begin col_l = {col_l[30:0], l_w}; col_l_n++; end
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         pos = 0;
      end else begin
         if (q.size() > 0) begin
            pos++;
            if (pos == W) begin
               void'(q.pop_front());
               pos = 0;
            end
         end
         if (acc) q.push_back(din);
      end
   endtask

   task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
      drive(r, v, d);
      model_check();
      finish_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
   endtask

   task automatic col_start();
      col_en = 1'b1;
      col_m = '0; col_l = '0;
      col_m_n = 0; col_l_n = 0;
   endtask

   vec_t tbl[12];

   initial begin
      // Reset, then single word 0x60 (MSB-first expectations).
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

      // One reset edge so registered outputs are defined before checking.
      drive(1'b1, 1'b0, '0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_w", i), 32'(m_w), 32'(tbl[i].ew));
         chk($sformatf("tbl%0d_w_valid", i), 32'(m_wv), 32'(tbl[i].ewv));
         chk($sformatf("tbl%0d_last", i), 32'(m_last), 32'(tbl[i].elast));
         chk($sformatf("tbl%0d_ready", i), 32'(m_ready), 32'(tbl[i].erdy));
         model_check();
         finish_cycle();
      end

      // Back-to-back via hold: 16 contiguous bits 0xA5 then 0x3C.
      cycle(1'b0, 1'b1, 8'hA5);
      col_start();
      cycle(1'b0, 1'b1, 8'h3C);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h3C);
      cycle(1'b0, 1'b1, 8'h3C);
      idle(8);
      col_en = 1'b0;
      chk("hold_stream_bits", col_m, 32'h0000A53C);
      chk("hold_stream_len", 32'(col_m_n), 32'd16);
      idle(2);

      // Bypass: 0x81 offered only in the last-bit cycle of 0xFF.
      cycle(1'b0, 1'b1, 8'hFF);
      col_start();
      idle(7);
      drive(1'b0, 1'b1, 8'h81);
      chk("bypass_ready", 32'(m_ready), 32'd1);
      model_check();
      finish_cycle();
      idle(8);
      col_en = 1'b0;
      chk("bypass_stream_bits", col_m, 32'h0000FF81);
      chk("bypass_stream_len", 32'(col_m_n), 32'd16);
      idle(2);

      // Reset mid-word with 0x55 held; 0x55 must never be shifted out.
      cycle(1'b0, 1'b1, 8'hFF);
      cycle(1'b0, 1'b1, 8'h55);
      idle(2);
      cycle(1'b1, 1'b0, '0);
      col_start();
      drive(1'b0, 1'b0, '0);
      chk("rst_mid_w", 32'(m_w), 32'd0);
      chk("rst_mid_w_valid", 32'(m_wv), 32'd0);
      chk("rst_mid_ready", 32'(m_ready), 32'd1);
      model_check();
      finish_cycle();
      idle(10);
      col_en = 1'b0;
      chk("rst_mid_no_bits", 32'(col_m_n), 32'd0);

      // LSB-first: 0x01 gives a 1 then seven 0s.
      cycle(1'b0, 1'b1, 8'h01);
      col_start();
      idle(9);
      col_en = 1'b0;
      chk("lsb_stream_bits", col_l, 32'h00000080);
      chk("lsb_stream_len", 32'(col_l_n), 32'd8);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), W'($urandom));
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
